// File: rtl/ddr_cas_responder.sv
// DRAM-side CAS responder: queues RD/WR commands until RL/WL expires, then
// streams bursts to/from an internal word array and reports completion and errors.
module ddr_cas_responder #(
  parameter int unsigned DQ_W  = 8,
  parameter int unsigned BL    = 8,
  parameter int unsigned COL_W = 10,
  parameter int unsigned BA_W  = 2,
  parameter int unsigned SLOTS = 8,
  parameter int unsigned TCCD  = 4,
  parameter logic [2:0]  RD_R  = 3'd1,
  parameter logic [2:0]  RDA_R = 3'd2,
  parameter logic [2:0]  WR_R  = 3'd3,
  parameter logic [2:0]  WRA_R = 3'd4
) (
  input  logic                CK_t,
  input  logic                reset,
  input  logic                cas_valid,
  input  logic [2:0]          cas_cmd,
  input  logic [BA_W-1:0]     cas_ba,
  input  logic [COL_W-1:0]    cas_col,
  input  logic [4:0]          CL,
  input  logic [4:0]          CWL,
  input  logic [4:0]          AL,
  input  logic [2*DQ_W-1:0]   dq_in,
  output logic [2*DQ_W-1:0]   dq_out,
  output logic                dq_oe,
  output logic                rw_done,
  output logic                ap_done,
  output logic [BA_W-1:0]     ap_ba,
  output logic                busy,
  output logic                err_tccd,
  output logic                err_full,
  output logic                err_conflict
);

  localparam int unsigned DW     = 2 * DQ_W;
  localparam int unsigned HALF   = BL / 2;
  localparam int unsigned L      = $clog2(HALF);
  localparam int unsigned AW     = BA_W + COL_W;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned LAT_W  = 6;
  localparam int unsigned GAP_W  = $clog2(TCCD + 1);
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [L-1:0] K_LAST = L'(HALF - 1);

  typedef struct packed {
    logic             wr;
    logic             ap;
    logic [BA_W-1:0]  ba;
    logic [COL_W-1:0] col;
    logic [LAT_W-1:0] cnt;
  } slot_t;

  typedef struct packed {
    logic             ap;
    logic [BA_W-1:0]  ba;
    logic [COL_W-1:0] col;
    logic [L-1:0]     k;
  } beat_t;

  typedef enum logic { IDLE = 1'b0, BURST = 1'b1 } eng_state_e;

  logic [DW-1:0]    mem [DEPTH];

  logic [SLOTS-1:0] slot_v_q, slot_v_d;
  slot_t            slot_q [SLOTS];
  slot_t            slot_d [SLOTS];
  eng_state_e       rd_st_q, rd_st_d, wr_st_q, wr_st_d;
  beat_t            rd_q, rd_d, wr_q, wr_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [LAT_W-1:0] rl, wl;
  logic             is_rd, is_wr, is_ap, cmd_legal, tccd_ok, accept;
  logic [SLOTS-1:0] expire;
  logic             free_ok, rd_hand, wr_hand;
  logic [SLOT_W-1:0] free_idx, rd_idx, wr_idx;
  logic             rd_done, wr_done;
  logic [AW-1:0]    rd_addr_d, wr_addr_d;

  logic [DW-1:0]    dq_out_d;
  logic             dq_oe_d, rw_done_d, ap_done_d, busy_d;
  logic             err_tccd_d, err_full_d, err_conflict_d;
  logic [BA_W-1:0]  ap_ba_d;

  // Word address wraps the beat index inside the aligned BL/2-word block.
  function automatic logic [AW-1:0] word_addr(input beat_t b);
    logic [L-1:0] low;
    low = b.col[L-1:0] + b.k;
    return {b.ba, b.col[COL_W-1:L], low};
  endfunction

  always_comb begin
    rl        = LAT_W'(AL) + LAT_W'(CL);
    wl        = LAT_W'(AL) + LAT_W'(CWL);
    is_rd     = (cas_cmd == RD_R) || (cas_cmd == RDA_R);
    is_wr     = (cas_cmd == WR_R) || (cas_cmd == WRA_R);
    is_ap     = (cas_cmd == RDA_R) || (cas_cmd == WRA_R);
    cmd_legal = cas_valid && (is_rd || is_wr);
    tccd_ok   = gap_q >= GAP_W'(TCCD);
  end

  // Slot scan: expiring slots count as free so they can be reloaded this clock.
  always_comb begin
    expire   = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    rd_hand  = 1'b0;
    rd_idx   = '0;
    wr_hand  = 1'b0;
    wr_idx   = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      expire[i] = slot_v_q[i] && (slot_q[i].cnt == '0);
      if (!slot_v_q[i] || expire[i]) begin
        free_ok  = 1'b1;
        free_idx = SLOT_W'(i);
      end
      if (expire[i] && !slot_q[i].wr) begin
        rd_hand = 1'b1;
        rd_idx  = SLOT_W'(i);
      end
      if (expire[i] && slot_q[i].wr) begin
        wr_hand = 1'b1;
        wr_idx  = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    accept     = cmd_legal && tccd_ok && free_ok;
    err_tccd_d = cmd_legal && !tccd_ok;
    err_full_d = cmd_legal && tccd_ok && !free_ok;

    slot_v_d = slot_v_q & ~expire;
    for (int i = 0; i < int'(SLOTS); i++) begin
      slot_d[i] = slot_q[i];
      if (slot_v_q[i] && (slot_q[i].cnt != '0)) begin
        slot_d[i].cnt = slot_q[i].cnt - LAT_W'(1);
      end
    end
    if (accept) begin
      slot_v_d[free_idx] = 1'b1;
      slot_d[free_idx]   = '{wr: is_wr, ap: is_ap, ba: cas_ba, col: cas_col,
                             cnt: is_wr ? (wl - LAT_W'(1)) : (rl - LAT_W'(1))};
    end

    // Dropped commands leave the gap counter running.
    if (accept) begin
      gap_d = GAP_W'(1);
    end else if (gap_q < GAP_W'(TCCD)) begin
      gap_d = gap_q + GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Engines: a hand-off restarts the burst, giving seamless back-to-back bursts.
  always_comb begin
    rd_st_d = IDLE;
    rd_d    = rd_q;
    if (rd_hand) begin
      rd_st_d = BURST;
      rd_d    = '{ap: slot_q[rd_idx].ap, ba: slot_q[rd_idx].ba,
                  col: slot_q[rd_idx].col, k: '0};
    end else if ((rd_st_q == BURST) && (rd_q.k != K_LAST)) begin
      rd_st_d = BURST;
      rd_d.k  = rd_q.k + L'(1);
    end

    wr_st_d = IDLE;
    wr_d    = wr_q;
    if (wr_hand) begin
      wr_st_d = BURST;
      wr_d    = '{ap: slot_q[wr_idx].ap, ba: slot_q[wr_idx].ba,
                  col: slot_q[wr_idx].col, k: '0};
    end else if ((wr_st_q == BURST) && (wr_q.k != K_LAST)) begin
      wr_st_d = BURST;
      wr_d.k  = wr_q.k + L'(1);
    end

    rd_addr_d = word_addr(rd_d);
    wr_addr_d = word_addr(wr_d);
    rd_done   = (rd_st_q == BURST) && (rd_q.k == K_LAST);
    wr_done   = (wr_st_q == BURST) && (wr_q.k == K_LAST);
  end

  always_comb begin
    dq_oe_d        = (rd_st_d == BURST);
    dq_out_d       = dq_oe_d ? mem[rd_addr_d] : '0;
    rw_done_d      = rd_done || wr_done;
    ap_done_d      = (rd_done && rd_q.ap) || (wr_done && wr_q.ap);
    ap_ba_d        = '0;
    if (rd_done && rd_q.ap) begin
      ap_ba_d = rd_q.ba;
    end else if (wr_done && wr_q.ap) begin
      ap_ba_d = wr_q.ba;
    end
    err_conflict_d = err_conflict || ((rd_st_d == BURST) && (wr_st_d == BURST));
    busy_d         = (|slot_v_d) || (rd_st_d == BURST) || (wr_st_d == BURST);
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      slot_v_q     <= '0;
      slot_q       <= '{default: '0};
      rd_st_q      <= IDLE;
      wr_st_q      <= IDLE;
      rd_q         <= '0;
      wr_q         <= '0;
      gap_q        <= GAP_W'(TCCD);
      dq_out       <= '0;
      dq_oe        <= 1'b0;
      rw_done      <= 1'b0;
      ap_done      <= 1'b0;
      ap_ba        <= '0;
      busy         <= 1'b0;
      err_tccd     <= 1'b0;
      err_full     <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      slot_v_q     <= slot_v_d;
      slot_q       <= slot_d;
      rd_st_q      <= rd_st_d;
      wr_st_q      <= wr_st_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      gap_q        <= gap_d;
      dq_out       <= dq_out_d;
      dq_oe        <= dq_oe_d;
      rw_done      <= rw_done_d;
      ap_done      <= ap_done_d;
      ap_ba        <= ap_ba_d;
      busy         <= busy_d;
      err_tccd     <= err_tccd_d;
      err_full     <= err_full_d;
      err_conflict <= err_conflict_d;
    end
  end

  // Storage is not reset; a same-clock read sees the pre-write contents.
  always_ff @(posedge CK_t) begin
    if (!reset && (wr_st_d == BURST)) begin
      mem[wr_addr_d] <= dq_in;
    end
  end

endmodule
